// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave core.
package spi_pkg;

   // Clock polarity / phase pair describing one SPI mode
   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

   // MOSI/MISO are sampled on the leading SCLK edge when cpha is 0
   function automatic logic spi_sample_on_leading(input logic cpha);
      return ~cpha;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes the asynchronous SPI pins into the aclk domain and detects
// SCLK leading/trailing edges (relative to cpol) and chip-select edges.
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic cpol,
   input  logic spi_sclk,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic sclk_lead,
   output logic sclk_trail,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_s,
   output logic cs_n_s
);

   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   sclk_prev_r;
   logic                   cs_prev_r;
   logic                   sclk_cur_s;
   logic                   sclk_chg_s;

   // Synchronizer chains plus one history stage for edge detection
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         cs_sync_r   <= {SYNC_STAGES{1'b1}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         sclk_prev_r <= 1'b0;
         cs_prev_r   <= 1'b1;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
         cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
      end
   end

   assign sclk_cur_s = sclk_sync_r[SYNC_STAGES-1];
   assign sclk_chg_s = sclk_cur_s ^ sclk_prev_r;

   // Leading edge leaves the idle level, trailing edge returns to it
   assign sclk_lead  = sclk_chg_s & (sclk_cur_s ^ cpol);
   assign sclk_trail = sclk_chg_s & ~(sclk_cur_s ^ cpol);
   assign cs_n_s     = cs_sync_r[SYNC_STAGES-1];
   assign cs_fall    = cs_prev_r & ~cs_n_s;
   assign cs_rise    = ~cs_prev_r & cs_n_s;
   assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core running entirely in the aclk domain, all four CPOL/CPHA
// modes, valid/ready TX and RX word interfaces, sticky overrun/underrun.
// Optional build macro SPI_SLAVE_CORE_LSB_FIRST_EN adds the lsb_first input.
module spi_slave_core #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  overrun,
   output logic                  underrun,
   input  logic                  clr_flags
`ifdef SPI_SLAVE_CORE_LSB_FIRST_EN
   ,
   input  logic                  lsb_first
`endif
);

   import spi_pkg::*;

   localparam int CNT_W = $clog2(DATA_WIDTH);

   logic                  sclk_lead_s, sclk_trail_s, cs_fall_s, cs_rise_s;
   logic                  mosi_s, cs_n_s, lsb_mode_s, idle_s;
   logic                  sample_edge_s, shift_edge_s, last_bit_s;
   logic                  start_s, commit_s, commit_full_s;
   logic [DATA_WIDTH-1:0] load_word_s, rx_next_s;

   logic [DATA_WIDTH-1:0] hold_r, tx_shift_r, rx_shift_r, rx_data_r;
   logic                  hold_full_r, copied_full_r, wrap_r, await_r;
   logic                  miso_r, rx_valid_r, overrun_r, underrun_r;
   logic [CNT_W-1:0]      bit_cnt_r;

`ifdef SPI_SLAVE_CORE_LSB_FIRST_EN
   assign lsb_mode_s = lsb_first;
`else
   assign lsb_mode_s = 1'b0;
`endif

   // Bit that leaves the shift register first for the selected bit order
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      if (lsb) return w[0];
      else     return w[DATA_WIDTH-1];
   endfunction

   // Shift register advanced by one bit in the selected direction
   function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
      if (lsb) return {1'b0, w[DATA_WIDTH-1:1]};
      else     return {w[DATA_WIDTH-2:0], 1'b0};
   endfunction

   spi_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .cpol       (cpol),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .sclk_lead  (sclk_lead_s),
      .sclk_trail (sclk_trail_s),
      .cs_fall    (cs_fall_s),
      .cs_rise    (cs_rise_s),
      .mosi_s     (mosi_s),
      .cs_n_s     (cs_n_s)
   );

   // SCLK edges only count while the synced chip select is low
   assign idle_s        = cs_n_s | cs_rise_s;
   assign sample_edge_s = ~idle_s & (spi_sample_on_leading(cpha) ? sclk_lead_s  : sclk_trail_s);
   assign shift_edge_s  = ~idle_s & (spi_sample_on_leading(cpha) ? sclk_trail_s : sclk_lead_s);
   assign last_bit_s    = (bit_cnt_r == CNT_W'(DATA_WIDTH - 1));
   assign load_word_s   = hold_full_r ? hold_r : {DATA_WIDTH{1'b0}};
   assign rx_next_s     = lsb_mode_s ? {mosi_s, rx_shift_r[DATA_WIDTH-1:1]}
                                     : {rx_shift_r[DATA_WIDTH-2:0], mosi_s};

   // A back-to-back word is copied into the shift register on the shift edge
   // after the last sample (so its first bit is on MISO in time) but only
   // committed, emptying the holding register or flagging underrun, on its
   // first sample edge. A frame that ends right after its last bit therefore
   // neither consumes a preloaded word nor reports a false underrun.
   assign start_s       = cs_fall_s | (shift_edge_s & wrap_r);
   assign commit_s      = cs_fall_s | (sample_edge_s & await_r);
   assign commit_full_s = cs_fall_s ? hold_full_r : copied_full_r;

   // TX holding register: loaded from the TX interface, emptied on commit
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hold_r      <= {DATA_WIDTH{1'b0}};
         hold_full_r <= 1'b0;
      end else begin
         if (commit_s && commit_full_s) begin
            hold_full_r <= 1'b0;
         end
         if (tx_valid && !hold_full_r) begin
            hold_r      <= tx_data;
            hold_full_r <= 1'b1;
         end
      end
   end

   // TX shift register and MISO driver, cleared whenever the slave is deselected
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tx_shift_r    <= {DATA_WIDTH{1'b0}};
         miso_r        <= 1'b0;
         copied_full_r <= 1'b0;
         wrap_r        <= 1'b0;
         await_r       <= 1'b0;
      end else if (idle_s) begin
         tx_shift_r    <= {DATA_WIDTH{1'b0}};
         miso_r        <= 1'b0;
         copied_full_r <= 1'b0;
         wrap_r        <= 1'b0;
         await_r       <= 1'b0;
      end else begin
         if (start_s) begin
            copied_full_r <= hold_full_r;
            wrap_r        <= 1'b0;
            await_r       <= ~cs_fall_s;
            if (cs_fall_s && cpha) begin
               tx_shift_r <= load_word_s;
            end else begin
               miso_r     <= first_bit(load_word_s, lsb_mode_s);
               tx_shift_r <= shift_word(load_word_s, lsb_mode_s);
            end
         end else if (shift_edge_s) begin
            miso_r     <= first_bit(tx_shift_r, lsb_mode_s);
            tx_shift_r <= shift_word(tx_shift_r, lsb_mode_s);
         end
         if (sample_edge_s && last_bit_s) begin
            wrap_r <= 1'b1;
         end
         if (sample_edge_s && await_r) begin
            await_r <= 1'b0;
         end
      end
   end

   // RX shift register, bit counter, word delivery and overrun detection
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rx_shift_r <= {DATA_WIDTH{1'b0}};
         bit_cnt_r  <= {CNT_W{1'b0}};
         rx_data_r  <= {DATA_WIDTH{1'b0}};
         rx_valid_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         if (rx_valid_r && rx_ready) begin
            rx_valid_r <= 1'b0;
         end
         if (clr_flags) begin
            overrun_r <= 1'b0;
         end
         if (idle_s) begin
            rx_shift_r <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
         end else if (sample_edge_s) begin
            rx_shift_r <= rx_next_s;
            if (last_bit_s) begin
               bit_cnt_r <= {CNT_W{1'b0}};
               if (!rx_valid_r) begin
                  rx_data_r  <= rx_next_s;
                  rx_valid_r <= 1'b1;
               end else begin
                  overrun_r <= 1'b1;
               end
            end else begin
               bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
         end
      end
   end

   // Underrun flag: a word committed with nothing in the holding register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         underrun_r <= 1'b0;
      end else begin
         if (clr_flags) begin
            underrun_r <= 1'b0;
         end
         if (commit_s && !commit_full_s) begin
            underrun_r <= 1'b1;
         end
      end
   end

   assign spi_miso    = miso_r & ~cs_n_s;
   assign spi_miso_oe = ~cs_n_s;
   assign busy        = ~cs_n_s;
   assign tx_ready    = ~hold_full_r;
   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign overrun     = overrun_r;
   assign underrun    = underrun_r;

endmodule
